// File: rtl/ram_ctrl_pkg.sv
// Shared types and defaults for the RAMblock bus controller.
// Optional feature macro: RAM_CTRL_WRITE_VERIFY_EN (adds GAP/VSTROBE states).
package ram_ctrl_pkg;

    localparam int ADDR_W_DEF  = 10;
    localparam int DATA_W_DEF  = 8;
    localparam int SETUP_DEF   = 1;
    localparam int STROBE_DEF  = 2;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WSTROBE,
        RSTROBE,
        HOLD
`ifdef RAM_CTRL_WRITE_VERIFY_EN
        ,
        GAP,
        VSTROBE
`endif
    } state_t;

    // Wait counter must hold the larger of the two timed lengths.
    function automatic int cnt_w(input int s, input int w);
        int m;
        m = (s > w) ? s : w;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/ram_bus_controller_if.sv
// Core-side req/ack transaction bundle for ram_bus_controller.
// master = core (req, we, addr_in, wdata); slave = controller (busy, ack, rdata, verify_err).
import ram_ctrl_pkg::*;

interface ram_bus_controller_if #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              ack;
    logic [DATA_W-1:0] rdata;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
    logic              verify_err;
`endif

    modport master (
        output req, we, addr_in, wdata,
`ifdef RAM_CTRL_WRITE_VERIFY_EN
        input  verify_err,
`endif
        input  busy, ack, rdata
    );

    modport slave (
        input  req, we, addr_in, wdata,
`ifdef RAM_CTRL_WRITE_VERIFY_EN
        output verify_err,
`endif
        output busy, ack, rdata
    );

endinterface

// File: rtl/ram_ctrl_wait_cnt.sv
// Loadable down-counter timing each phase; stops at 1.
// Ports: clk, reset, load, val (load value) -> done (count == 1).
module ram_ctrl_wait_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= val;
        else if (cnt > W'(1))
            cnt <= cnt - W'(1);
    end

    assign done = (cnt == W'(1));

endmodule

// File: rtl/ram_bus_controller.sv
// Sequences single-byte reads/writes onto RAMblock with setup/strobe/hold timing.
// Ports: clk, reset, bus (slave), ram_address, ram_data (inout), ram_read, ram_write.
// Macro RAM_CTRL_WRITE_VERIFY_EN adds a read-back after each write and verify_err.
import ram_ctrl_pkg::*;

module ram_bus_controller #(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int SETUP_CYCLES  = SETUP_DEF,
    parameter int STROBE_CYCLES = STROBE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    ram_bus_controller_if.slave bus,
    output logic [ADDR_W-1:0] ram_address,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic              ram_read,
    output logic              ram_write
);

    localparam int CW = cnt_w(SETUP_CYCLES, STROBE_CYCLES);

    state_t            state;
    state_t            nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              we_q;
    logic              ld;
    logic [CW-1:0]     ld_val;
    logic              done;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
    logic              verr_q;
`endif

    ram_ctrl_wait_cnt #(.W(CW)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (ld),
        .val   (ld_val),
        .done  (done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
            verr_q  <= 1'b0;
`endif
        end else begin
            state <= nxt;
            if (state == IDLE && bus.req) begin
                addr_q  <= bus.addr_in;
                wdata_q <= bus.wdata;
                we_q    <= bus.we;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
                verr_q  <= 1'b0;
`endif
            end
            // Capture on the edge that ends the last strobe cycle.
            if (state == RSTROBE && done)
                rdata_q <= ram_data;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
            if (state == VSTROBE && done) begin
                rdata_q <= ram_data;
                verr_q  <= (ram_data != wdata_q);
            end
`endif
        end
    end

    // Counter is loaded on the edge entering each timed state.
    always_comb begin
        nxt    = state;
        ld     = 1'b0;
        ld_val = CW'(SETUP_CYCLES);
        unique case (state)
            IDLE: begin
                if (bus.req) begin
                    nxt    = SETUP;
                    ld     = 1'b1;
                    ld_val = CW'(SETUP_CYCLES);
                end
            end
            SETUP: begin
                if (done) begin
                    nxt    = we_q ? WSTROBE : RSTROBE;
                    ld     = 1'b1;
                    ld_val = CW'(STROBE_CYCLES);
                end
            end
            WSTROBE: begin
                if (done) begin
`ifdef RAM_CTRL_WRITE_VERIFY_EN
                    nxt    = GAP;
                    ld     = 1'b1;
                    ld_val = CW'(1);
`else
                    nxt    = HOLD;
`endif
                end
            end
            RSTROBE: begin
                if (done)
                    nxt = HOLD;
            end
`ifdef RAM_CTRL_WRITE_VERIFY_EN
            GAP: begin
                nxt    = VSTROBE;
                ld     = 1'b1;
                ld_val = CW'(STROBE_CYCLES);
            end
            VSTROBE: begin
                if (done)
                    nxt = HOLD;
            end
`endif
            HOLD:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    assign ram_write   = (state == WSTROBE);
`ifdef RAM_CTRL_WRITE_VERIFY_EN
    assign ram_read    = (state == RSTROBE) || (state == VSTROBE);
    assign bus.verify_err = verr_q;
`else
    assign ram_read    = (state == RSTROBE);
`endif
    assign ram_address = addr_q;
    // Bus is only driven while writing; RAMblock owns it otherwise.
    assign ram_data    = ram_write ? wdata_q : {DATA_W{1'bz}};

    assign bus.busy  = (state != IDLE);
    assign bus.ack   = (state == HOLD);
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_ram_bus_controller.sv
// Self-checking bench for ram_bus_controller with a 1K x 8 RAMblock model.
// Expected read data is queued at issue time and compared on ack.
module tb_ram_bus_controller;

    localparam int S = 1;
    localparam int W = 2;

    logic       clk;
    logic       reset;
    logic [9:0] ram_address;
    wire  [7:0] ram_data;
    logic       ram_read;
    logic       ram_write;

    ram_bus_controller_if bus ();

    ram_bus_controller dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_read    (ram_read),
        .ram_write   (ram_write)
    );

    logic [7:0] mem [1024];
    logic [7:0] model [1024];
    logic       stuck;
    logic [7:0] rd_val;
    logic [7:0] exp_q [$];

    int n_run;
    int n_fail;

    assign rd_val   = mem[ram_address] & (stuck ? 8'hFE : 8'hFF);
    assign ram_data = ram_read ? rd_val : 8'hzz;

    always @(posedge clk)
        if (ram_write)
            mem[ram_address] <= ram_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One transaction; req is raised at this negedge (relative cycle 0).
    // off = cycles before the controller can accept (1 if called on ack).
    task automatic txn(input logic w, input logic [9:0] a,
                       input logic [7:0] d, input bit keep,
                       input int off, input bit exp_ve,
                       input string tag);
        int ack_c, fw, nw, fr, nr, exp_ack;
        bit busy_bad, data_bad, addr_bad, both_bad, ve1;
        logic [7:0] e;
        bit verify;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
        verify = 1'b1;
`else
        verify = 1'b0;
`endif
        if (!w) exp_q.push_back(model[a]);
        else    model[a] = d;
        bus.req = 1'b1;
        bus.we = w;
        bus.addr_in = a;
        bus.wdata = d;
        ack_c = -1; fw = -1; fr = -1; nw = 0; nr = 0;
        busy_bad = 0; data_bad = 0; addr_bad = 0;
        both_bad = 0; ve1 = 0;
        if (w && verify) exp_ack = off + S + 2 * W + 2;
        else             exp_ack = off + S + W + 1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (cyc == off + 1 && !keep) bus.req = 1'b0;
            if (bus.busy !== (cyc >= off + 1 && cyc <= exp_ack))
                busy_bad = 1;
            if (ram_write) begin
                if (fw < 0) fw = cyc;
                nw++;
                if (ram_data !== d) data_bad = 1;
            end
            if (ram_read) begin
                if (fr < 0) fr = cyc;
                nr++;
            end
            if (ram_read && ram_write) both_bad = 1;
            if ((ram_read || ram_write || bus.ack) && ram_address !== a)
                addr_bad = 1;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
            if (cyc == off + 1 && bus.verify_err !== 1'b0) ve1 = 1;
            if (bus.ack && w)
                check({tag, "_verr"}, bus.verify_err, exp_ve);
`endif
            if (bus.ack) begin
                ack_c = cyc;
                break;
            end
        end
        check({tag, "_ack_cyc"}, ack_c, exp_ack);
        check({tag, "_busy"}, busy_bad, 0);
        check({tag, "_addr"}, addr_bad, 0);
        check({tag, "_both"}, both_bad, 0);
        if (verify) check({tag, "_verr_clr"}, ve1, 0);
        else        check({tag, "_ve_n"}, exp_ve, 0);
        if (w) begin
            check({tag, "_wr_first"}, fw, off + S + 1);
            check({tag, "_wr_cnt"}, nw, W);
            check({tag, "_wr_data"}, data_bad, 0);
            check({tag, "_rd_cnt"}, nr, verify ? W : 0);
        end else begin
            check({tag, "_rd_first"}, fr, off + S + 1);
            check({tag, "_rd_cnt"}, nr, W);
            check({tag, "_wr_cnt"}, nw, 0);
            e = exp_q.pop_front();
            check({tag, "_rdata"}, bus.rdata, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_run = 0;
        n_fail = 0;
        stuck = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 8'h00;
            model[i] = 8'h00;
        end
        reset = 1'b1;
        bus.req = 1'b1;
        bus.we = 1'b1;
        bus.addr_in = 10'h3;
        bus.wdata = 8'hAA;

        // Reset held with req high
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_ack", bus.ack, 0);
        check("rst_rd", ram_read, 0);
        check("rst_wr", ram_write, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_addr", ram_address, 0);
`ifdef RAM_CTRL_WRITE_VERIFY_EN
        check("rst_verr", bus.verify_err, 0);
`endif
        bus.req = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", bus.busy, 0);

        txn(1'b1, 10'd1, 8'h05, 0, 0, 0, "w1");
        @(negedge clk);
        check("mem1", mem[1], 8'h05);
        txn(1'b1, 10'd2, 8'h0A, 0, 0, 0, "w2");
        @(negedge clk);
        txn(1'b0, 10'd1, 8'h00, 0, 0, 0, "r1");
        @(negedge clk);

        // Back-to-back with req held continuously
        txn(1'b1, 10'h3FF, 8'hFF, 1, 0, 0, "b2b_w");
        txn(1'b0, 10'h3FF, 8'h00, 0, 1, 0, "b2b_r");
        @(negedge clk);

        // Reset during the second write strobe cycle
        bus.req = 1'b1;
        bus.we = 1'b1;
        bus.addr_in = 10'd10;
        bus.wdata = 8'h77;
        model[10] = 8'h77;
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        check("mr_wr2", ram_write, 1);
        @(negedge clk);
        check("mr_wr3", ram_write, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mr_wr", ram_write, 0);
        check("mr_rd", ram_read, 0);
        check("mr_busy", bus.busy, 0);
        begin
            bit acked;
            acked = 0;
            check("mr_ack0", bus.ack, 0);
            repeat (4) begin
                @(negedge clk);
                if (bus.ack) acked = 1;
            end
            check("mr_noack", acked, 0);
        end

        txn(1'b0, 10'd1, 8'h00, 0, 0, 0, "r1b");
        @(negedge clk);
        txn(1'b0, 10'd2, 8'h00, 0, 0, 0, "r2");
        @(negedge clk);

`ifdef RAM_CTRL_WRITE_VERIFY_EN
        txn(1'b1, 10'd7, 8'h5A, 0, 0, 0, "v_ok");
        @(negedge clk);
        stuck = 1'b1;
        txn(1'b1, 10'd8, 8'h5B, 0, 0, 1, "v_bad");
        @(negedge clk);
        txn(1'b0, 10'd7, 8'h00, 0, 0, 0, "v_rd");
        stuck = 1'b0;
        @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
